lcd_message_sequencer: RTL and testbench

Upstream command source for `LCD_executor`. Holds a 32-character message buffer (two lines × 16) that the host writes. On request it refreshes the LCD by issuing this command sequence to the executor over its `ENB`/`OP`/`DATA`/`RDY` handshake, one command per `RDY` pulse:

- clear
- DDRAM address 0x00, then 16 character writes
- DDRAM address 0x40, then 16 character writes
- (optionally) a 2 s wait, then repeat

---
 rtl/lcd_message_sequencer.sv | 129 ++++++++++++
 tb/tb_lcd_message_sequencer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_message_sequencer.sv
// Command source for an LCD executor: holds a 2x16 character buffer and replays it as
// clear / address / character-write commands, one command per executor RDY pulse.
module lcd_message_sequencer #(
   parameter int          AUTO_REFRESH = 0,
   parameter logic [7:0]  BLANK_CHAR   = 8'h20
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       WR_EN,
   input  logic [4:0] WR_ADDR,
   input  logic [7:0] WR_DATA,
   input  logic       START,
   input  logic       EXE_RDY,
   output logic       EXE_ENB,
   output logic [3:0] EXE_OP,
   output logic [7:0] EXE_DATA,
   output logic       BUSY,
   output logic       DONE
);

   localparam logic [3:0] OP_CLEAR = 4'd0;
   localparam logic [3:0] OP_WRITE = 4'd1;
   localparam logic [3:0] OP_ADDR  = 4'd3;
   localparam logic [3:0] OP_WAIT  = 4'd4;
   localparam logic [3:0] OP_NOP   = 4'd15;

   // State names the command currently held in the output registers.
   typedef enum logic [2:0] {
      S_IDLE, S_CLR, S_ADDR1, S_LINE1, S_ADDR2, S_LINE2, S_PAUSE
   } state_t;

   state_t     state_q, state_d;
   logic [3:0] idx_q, idx_d;
   logic       pend_q, pend_d;
   logic [3:0] op_q, op_d;
   logic [7:0] data_q, data_d;
   logic       done_q, done_d;
   logic       enb_q;
   logic [7:0] buf_q [32];

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < 32; i++) buf_q[i] <= BLANK_CHAR;
      end else if (WR_EN) begin
         buf_q[WR_ADDR] <= WR_DATA;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= S_IDLE;
         idx_q   <= 4'd0;
         pend_q  <= 1'b0;
         op_q    <= OP_NOP;
         data_q  <= 8'h00;
         done_q  <= 1'b0;
         enb_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         pend_q  <= pend_d;
         op_q    <= op_d;
         data_q  <= data_d;
         done_q  <= done_d;
         enb_q   <= 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      pend_d  = pend_q | START;
      op_d    = op_q;
      data_d  = data_q;
      done_d  = 1'b0;
      if (EXE_RDY) begin
         case (state_q)
            S_IDLE:  if (pend_q || START) state_d = S_CLR;
            S_CLR:   state_d = S_ADDR1;
            S_ADDR1: begin
               state_d = S_LINE1;
               idx_d   = 4'd0;
            end
            S_LINE1: begin
               if (idx_q != 4'd15) idx_d = idx_q + 4'd1;
               else                state_d = S_ADDR2;
            end
            S_ADDR2: begin
               state_d = S_LINE2;
               idx_d   = 4'd0;
            end
            S_LINE2: begin
               if (idx_q != 4'd15) begin
                  idx_d = idx_q + 4'd1;
               end else if (AUTO_REFRESH != 0) begin
                  state_d = S_PAUSE;
               end else begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end
            end
            S_PAUSE: state_d = S_CLR;
            default: state_d = S_IDLE;
         endcase

         // Loading CLR consumes any request, including one arriving this cycle.
         if (state_d == S_CLR) pend_d = 1'b0;

         // Buffer is read before this edge's write lands, so a colliding write sends the old byte.
         case (state_d)
            S_IDLE:  begin op_d = OP_NOP;   data_d = 8'h00;                 end
            S_CLR:   begin op_d = OP_CLEAR; data_d = 8'h00;                 end
            S_ADDR1: begin op_d = OP_ADDR;  data_d = 8'h00;                 end
            S_LINE1: begin op_d = OP_WRITE; data_d = buf_q[{1'b0, idx_d}];  end
            S_ADDR2: begin op_d = OP_ADDR;  data_d = 8'h40;                 end
            S_LINE2: begin op_d = OP_WRITE; data_d = buf_q[{1'b1, idx_d}];  end
            S_PAUSE: begin op_d = OP_WAIT;  data_d = 8'h00;                 end
            default: begin op_d = OP_NOP;   data_d = 8'h00;                 end
         endcase
      end
   end

   assign EXE_ENB  = enb_q;
   assign EXE_OP   = op_q;
   assign EXE_DATA = data_q;
   assign BUSY     = (op_q != OP_NOP) || pend_q;
   assign DONE     = done_q;

endmodule

// File: tb/tb_lcd_message_sequencer.sv
// Bench for lcd_message_sequencer: an executor model pulsing RDY every 4 cycles, checked
// against hand-built command tables and a small buffer model.
module tb_lcd_message_sequencer;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       WR_EN = 1'b0;
   logic [4:0] WR_ADDR = 5'd0;
   logic [7:0] WR_DATA = 8'd0;
   logic       START = 1'b0;
   logic       START_A = 1'b0;
   logic       EXE_RDY = 1'b0;
   logic       EXE_ENB, BUSY, DONE;
   logic [3:0] EXE_OP;
   logic [7:0] EXE_DATA;
   logic       A_ENB, A_BUSY, A_DONE;
   logic [3:0] A_OP;
   logic [7:0] A_DATA;

   always #5 CLK = ~CLK;

   lcd_message_sequencer #(.AUTO_REFRESH(0), .BLANK_CHAR(8'h20)) dut (
      .CLK(CLK), .RST(RST), .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
      .START(START), .EXE_RDY(EXE_RDY), .EXE_ENB(EXE_ENB), .EXE_OP(EXE_OP),
      .EXE_DATA(EXE_DATA), .BUSY(BUSY), .DONE(DONE)
   );

   lcd_message_sequencer #(.AUTO_REFRESH(1), .BLANK_CHAR(8'h20)) dut_a (
      .CLK(CLK), .RST(RST), .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
      .START(START_A), .EXE_RDY(EXE_RDY), .EXE_ENB(A_ENB), .EXE_OP(A_OP),
      .EXE_DATA(A_DATA), .BUSY(A_BUSY), .DONE(A_DONE)
   );

   typedef struct {
      logic [3:0] op;
      logic [7:0] data;
      logic       done;
   } vec_t;

   int          checks = 0;
   int          failures = 0;
   int          done_cnt = 0;
   int          a_done_cnt = 0;
   logic [7:0]  mdl_buf [32];
   logic [12:0] exp_q [$];
   logic [3:0]  s_op, a_op;
   logic [7:0]  s_data, a_data;
   logic        s_done, a_done;

   always @(negedge CLK) begin
      if (DONE)   done_cnt++;
      if (A_DONE) a_done_cnt++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
      end
   endtask

   // One executor handshake: RDY high for one cycle, sample one cycle later.
   task automatic hs(input logic wr, input logic [4:0] a, input logic [7:0] d);
      @(negedge CLK);
      EXE_RDY = 1'b1;
      if (wr) begin
         WR_EN = 1'b1; WR_ADDR = a; WR_DATA = d;
      end
      @(negedge CLK);
      EXE_RDY = 1'b0;
      WR_EN   = 1'b0;
      s_op = EXE_OP; s_data = EXE_DATA; s_done = DONE;
      a_op = A_OP;   a_data = A_DATA;   a_done = A_DONE;
      repeat (2) @(negedge CLK);
   endtask

   task automatic wr(input logic [4:0] a, input logic [7:0] d);
      @(negedge CLK);
      WR_EN = 1'b1; WR_ADDR = a; WR_DATA = d;
      @(negedge CLK);
      WR_EN = 1'b0;
      mdl_buf[a] = d;
   endtask

   task automatic pulse_start(input bit use_a);
      @(negedge CLK);
      if (use_a) START_A = 1'b1; else START = 1'b1;
      @(negedge CLK);
      START = 1'b0; START_A = 1'b0;
      if (use_a) chk("busy_after_start_a", A_BUSY, 1);
      else       chk("busy_after_start", BUSY, 1);
   endtask

   task automatic push_refresh(input logic [3:0] fop, input logic fdone);
      exp_q.push_back({1'b0, 4'd0, 8'h00});
      exp_q.push_back({1'b0, 4'd3, 8'h00});
      for (int i = 0; i < 16; i++) exp_q.push_back({1'b0, 4'd1, mdl_buf[i]});
      exp_q.push_back({1'b0, 4'd3, 8'h40});
      for (int i = 0; i < 16; i++) exp_q.push_back({1'b0, 4'd1, mdl_buf[16+i]});
      exp_q.push_back({fdone, fop, 8'h00});
   endtask

   task automatic run_exp(input string nm, input bit use_a, input int wr_at,
                          input logic [7:0] wr_d, input int st0, input int st1);
      int k;
      logic [12:0] e;
      k = 0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (k == st0 || k == st1) pulse_start(1'b0);
         hs(k == wr_at, 5'd3, wr_d);
         if (use_a) begin
            chk($sformatf("%s_op%0d", nm, k), a_op, e[11:8]);
            chk($sformatf("%s_data%0d", nm, k), a_data, e[7:0]);
            chk($sformatf("%s_done%0d", nm, k), a_done, e[12]);
         end else begin
            chk($sformatf("%s_op%0d", nm, k), s_op, e[11:8]);
            chk($sformatf("%s_data%0d", nm, k), s_data, e[7:0]);
            chk($sformatf("%s_done%0d", nm, k), s_done, e[12]);
         end
         k++;
      end
   endtask

   initial begin
      vec_t       tbl [36];
      logic [7:0] l1 [16];
      logic [7:0] l2 [16];
      int         base;

      for (int i = 0; i < 16; i++) begin l1[i] = 8'h20; l2[i] = 8'h20; end
      l1[0] = 8'h48; l1[1] = 8'h45; l1[2] = 8'h4C; l1[3] = 8'h4C; l1[4] = 8'h4F;
      l2[0] = 8'h57; l2[1] = 8'h4F; l2[2] = 8'h52; l2[3] = 8'h4C; l2[4] = 8'h44;
      tbl[0]  = '{op: 4'd0,  data: 8'h00, done: 1'b0};
      tbl[1]  = '{op: 4'd3,  data: 8'h00, done: 1'b0};
      for (int i = 0; i < 16; i++) tbl[2+i] = '{op: 4'd1, data: l1[i], done: 1'b0};
      tbl[18] = '{op: 4'd3,  data: 8'h40, done: 1'b0};
      for (int i = 0; i < 16; i++) tbl[19+i] = '{op: 4'd1, data: l2[i], done: 1'b0};
      tbl[35] = '{op: 4'd15, data: 8'h00, done: 1'b1};
      for (int i = 0; i < 32; i++) mdl_buf[i] = 8'h20;

      // Reset values and enable timing
      repeat (3) @(negedge CLK);
      chk("rst_enb", EXE_ENB, 0);
      chk("rst_op", EXE_OP, 15);
      chk("rst_data", EXE_DATA, 0);
      chk("rst_busy", BUSY, 0);
      chk("rst_done", DONE, 0);
      RST = 1'b0;
      #1 chk("enb_before_edge", EXE_ENB, 0);
      @(negedge CLK);
      chk("enb_after_release", EXE_ENB, 1);
      chk("op_after_release", EXE_OP, 15);

      // Idle polling keeps the nop loaded
      for (int i = 0; i < 3; i++) begin
         hs(1'b0, 5'd0, 8'd0);
         chk($sformatf("idle_op%0d", i), s_op, 15);
         chk($sformatf("idle_busy%0d", i), BUSY, 0);
      end

      // HELLO / WORLD refresh against the fixed table
      for (int i = 0; i < 5; i++) begin
         wr(5'(i), l1[i]);
         wr(5'(16 + i), l2[i]);
      end
      base = done_cnt;
      pulse_start(1'b0);
      for (int i = 0; i < 36; i++) begin
         hs(1'b0, 5'd0, 8'd0);
         chk($sformatf("tbl_op%0d", i), s_op, tbl[i].op);
         chk($sformatf("tbl_data%0d", i), s_data, tbl[i].data);
         chk($sformatf("tbl_done%0d", i), s_done, tbl[i].done);
      end
      chk("hello_busy_end", BUSY, 0);
      chk("hello_done_count", done_cnt - base, 1);

      // Two starts during a refresh merge into exactly one further refresh
      base = done_cnt;
      pulse_start(1'b0);
      push_refresh(4'd15, 1'b1);
      push_refresh(4'd15, 1'b1);
      run_exp("dbl", 1'b0, -1, 8'h00, 5, 12);
      hs(1'b0, 5'd0, 8'd0);
      chk("dbl_idle_op", s_op, 15);
      hs(1'b0, 5'd0, 8'd0);
      chk("dbl_idle_op2", s_op, 15);
      chk("dbl_busy_end", BUSY, 0);
      chk("dbl_done_count", done_cnt - base, 2);

      // Write to index 3 on the edge that loads it: old byte sent, new byte kept
      pulse_start(1'b0);
      push_refresh(4'd15, 1'b1);
      run_exp("coll", 1'b0, 5, 8'h41, -1, -1);
      mdl_buf[3] = 8'h41;
      pulse_start(1'b0);
      push_refresh(4'd15, 1'b1);
      run_exp("coll_next", 1'b0, -1, 8'h00, -1, -1);

      // Auto-refresh instance: wait command then restart, never DONE
      base = a_done_cnt;
      pulse_start(1'b1);
      push_refresh(4'd4, 1'b0);
      exp_q.push_back({1'b0, 4'd0, 8'h00});
      run_exp("auto", 1'b1, -1, 8'h00, -1, -1);
      chk("auto_busy", A_BUSY, 1);
      chk("auto_done_count", a_done_cnt - base, 0);

      // Reset in LINE1 at idx 7
      pulse_start(1'b0);
      for (int i = 0; i < 10; i++) hs(1'b0, 5'd0, 8'd0);
      chk("mid_op", s_op, 1);
      chk("mid_data", s_data, mdl_buf[7]);
      @(negedge CLK);
      RST = 1'b1;
      #1;
      chk("mid_rst_enb", EXE_ENB, 0);
      chk("mid_rst_op", EXE_OP, 15);
      chk("mid_rst_data", EXE_DATA, 0);
      chk("mid_rst_busy", BUSY, 0);
      chk("mid_rst_done", DONE, 0);
      @(negedge CLK);
      RST = 1'b0;
      for (int i = 0; i < 32; i++) mdl_buf[i] = 8'h20;
      @(negedge CLK);
      pulse_start(1'b0);
      push_refresh(4'd15, 1'b1);
      run_exp("blank", 1'b0, -1, 8'h00, -1, -1);
      chk("blank_busy_end", BUSY, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
